// File: rtl/data_memory_unit_pkg.sv
// Shared definitions for the data-memory stage: bus command codes, MMIO
// register addresses, FSM state encoding and the timer control word layout.
package data_memory_unit_pkg;

    localparam logic [7:0] CMD_READ      = 8'h00;
    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
    localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;
    localparam logic [7:0] ADDR_TMR_CNT  = 8'hF2;
    localparam logic [7:0] ADDR_TMR_CTL  = 8'hF3;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Read-back layout of the timer control register.
    function automatic logic [7:0] tmr_ctl_word(input logic ovf, input logic en);
        return {6'b000000, ovf, en};
    endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Command/address side of the CU-to-data-memory port; the shared data bus
// stays a top-level inout so the tri-state resolves on a plain net.
interface data_memory_unit_if;

    logic [7:0] cmd_memory;
    logic [7:0] addr_memory;

    modport master (
        output cmd_memory,
        output addr_memory
    );

    modport slave (
        input cmd_memory,
        input addr_memory
    );

endinterface

// File: rtl/data_memory_unit_mmio_timer.sv
// Free-running 8-bit MMIO timer with load, enable and a sticky overflow flag
// that is cleared by writing 1 to control bit 1.
module mmio_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [7:0] load_val,
    input  logic       ctl_we,
    input  logic [1:0] ctl_wdata,
    output logic [7:0] tmr_cnt,
    output logic       tmr_en,
    output logic       timer_ovf
);

    logic [7:0] cnt_q, cnt_d;
    logic       en_q, en_d;
    logic       ovf_q, ovf_d;
    logic       wrap_s;

    // Next-state: a load pre-empts both counting and the wrap it would cause.
    always_comb begin
        cnt_d  = cnt_q;
        en_d   = en_q;
        ovf_d  = ovf_q;
        wrap_s = 1'b0;
        if (load_en) begin
            cnt_d = load_val;
        end else if (en_q) begin
            cnt_d  = cnt_q + 8'd1;
            wrap_s = (cnt_q == 8'hFF);
        end else begin
            cnt_d = cnt_q;
        end
        if (ctl_we) begin
            en_d = ctl_wdata[0];
        end else begin
            en_d = en_q;
        end
        if (wrap_s) begin
            ovf_d = 1'b1;
        end else if (ctl_we && ctl_wdata[1]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'h00;
            en_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            ovf_q <= ovf_d;
        end
    end

    assign tmr_cnt   = cnt_q;
    assign tmr_en    = en_q;
    assign timer_ovf = ovf_q;

endmodule

// File: rtl/data_memory_unit.sv
// Data-memory stage: 240 B RAM plus GPIO/timer MMIO window, zero-fill sweep
// after reset, single-commit write detection and combinational read drive.
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int unsigned RAM_DEPTH      = 240,
    parameter logic [7:0]  MMIO_BASE      = 8'hF0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_memory_unit_if.slave    bus,
    inout  wire  [7:0]           data_memory,
    input  logic [7:0]           gpio_in,
    output logic [7:0]           gpio_out,
    output logic                 timer_ovf,
    output logic                 mem_ready
);

    localparam logic [7:0] CLR_LAST  = 8'(RAM_DEPTH - 1);
    localparam state_e     RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    logic [7:0] ram_q [RAM_DEPTH];

    state_e     state_q, state_d;
    logic [7:0] clr_addr_q, clr_addr_d;
    logic       mem_ready_q, mem_ready_d;
    logic [7:0] gpio_out_q, gpio_out_d;
    logic [7:0] gpio_meta_q, gpio_sync_q;
    logic [7:0] prev_cmd_q, prev_addr_q;

    logic       commit_s;
    logic       ram_we_s;
    logic [7:0] ram_waddr_s, ram_wdata_s;
    logic [7:0] wr_data_s;
    logic [7:0] rd_data_s;
    logic       drive_s;
    logic       tmr_load_s, tmr_ctl_we_s;
    logic [7:0] tmr_cnt_s;
    logic       tmr_en_s, tmr_ovf_s;

    assign wr_data_s = data_memory;

    // A held WRITE (CU already released the bus) must not commit a second time.
    always_comb begin
        commit_s = 1'b0;
        if ((state_q == ST_RUN) && (bus.cmd_memory == CMD_WRITE)) begin
            commit_s = (prev_cmd_q != CMD_WRITE) || (prev_addr_q != bus.addr_memory);
        end else begin
            commit_s = 1'b0;
        end
    end

    // Clear-sweep FSM, RAM write port selection and GPIO output register.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        mem_ready_d = mem_ready_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = clr_addr_q;
        ram_wdata_s = 8'h00;
        gpio_out_d  = gpio_out_q;
        case (state_q)
            ST_CLEAR: begin
                ram_we_s   = 1'b1;
                clr_addr_d = clr_addr_q + 8'd1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d     = ST_RUN;
                    mem_ready_d = 1'b1;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                mem_ready_d = 1'b1;
                if (commit_s && (bus.addr_memory < MMIO_BASE)) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = bus.addr_memory;
                    ram_wdata_s = wr_data_s;
                end else begin
                    ram_we_s = 1'b0;
                end
                if (commit_s && (bus.addr_memory == ADDR_GPIO_OUT)) begin
                    gpio_out_d = wr_data_s;
                end else begin
                    gpio_out_d = gpio_out_q;
                end
            end
            default: begin
                state_d     = RST_STATE;
                clr_addr_d  = 8'h00;
                mem_ready_d = 1'b0;
            end
        endcase
    end

    assign tmr_load_s   = commit_s && (bus.addr_memory == ADDR_TMR_CNT);
    assign tmr_ctl_we_s = commit_s && (bus.addr_memory == ADDR_TMR_CTL);

    // Control, GPIO and write-detect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            clr_addr_q  <= 8'h00;
            mem_ready_q <= 1'b0;
            gpio_out_q  <= 8'h00;
            gpio_meta_q <= 8'h00;
            gpio_sync_q <= 8'h00;
            prev_cmd_q  <= 8'hFF;
            prev_addr_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            mem_ready_q <= mem_ready_d;
            gpio_out_q  <= gpio_out_d;
            gpio_meta_q <= gpio_in;
            gpio_sync_q <= gpio_meta_q;
            prev_cmd_q  <= bus.cmd_memory;
            prev_addr_q <= bus.addr_memory;
        end
    end

    // RAM storage: contents survive reset and are zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_q[ram_waddr_s] <= ram_wdata_s;
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_en   (tmr_load_s),
        .load_val  (wr_data_s),
        .ctl_we    (tmr_ctl_we_s),
        .ctl_wdata (wr_data_s[1:0]),
        .tmr_cnt   (tmr_cnt_s),
        .tmr_en    (tmr_en_s),
        .timer_ovf (tmr_ovf_s)
    );

    // Read mux; the RAM is still being cleared until RUN so it reads as zero.
    always_comb begin
        rd_data_s = 8'h00;
        if (state_q != ST_RUN) begin
            rd_data_s = 8'h00;
        end else if (bus.addr_memory < MMIO_BASE) begin
            rd_data_s = ram_q[bus.addr_memory];
        end else begin
            case (bus.addr_memory)
                ADDR_GPIO_OUT: rd_data_s = gpio_out_q;
                ADDR_GPIO_IN:  rd_data_s = gpio_sync_q;
                ADDR_TMR_CNT:  rd_data_s = tmr_cnt_s;
                ADDR_TMR_CTL:  rd_data_s = tmr_ctl_word(tmr_ovf_s, tmr_en_s);
                default:       rd_data_s = 8'h00;
            endcase
        end
    end

    assign drive_s     = !rst && (bus.cmd_memory == CMD_READ);
    assign data_memory = drive_s ? rd_data_s : 8'hzz;

    assign gpio_out  = gpio_out_q;
    assign timer_ovf = tmr_ovf_s;
    assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: directed scenarios then random
// traffic, all checked against a behavioural model of the memory map.
module tb_data_memory_unit;
    import data_memory_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_unit_if bus_if();
    wire  [7:0] data_memory;
    logic       tb_drv   = 1'b0;
    logic [7:0] tb_wdata = 8'h00;
    logic [7:0] gpio_in  = 8'h00;
    logic [7:0] gpio_out;
    logic       timer_ovf;
    logic       mem_ready;

    assign data_memory = tb_drv ? tb_wdata : 8'hzz;

    data_memory_unit dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave),
        .data_memory (data_memory),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .timer_ovf   (timer_ovf),
        .mem_ready   (mem_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tag_q[$];

    // Reference model of the visible memory map
    logic [7:0] m_ram [0:239];
    logic [7:0] m_gpio_out, m_cnt, m_s1, m_s2, m_prev_cmd, m_prev_addr;
    logic       m_en, m_ovf, m_ready;
    int         m_clr_edges;

    task automatic model_reset();
        m_gpio_out = 8'h00; m_cnt = 8'h00; m_en = 1'b0; m_ovf = 1'b0;
        m_s1 = 8'h00; m_s2 = 8'h00; m_prev_cmd = 8'hFF; m_prev_addr = 8'h00;
        m_ready = 1'b0; m_clr_edges = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (!m_ready) return 8'h00;
        if (a < 8'hF0) return m_ram[a];
        if (a == 8'hF0) return m_gpio_out;
        if (a == 8'hF1) return m_s2;
        if (a == 8'hF2) return m_cnt;
        if (a == 8'hF3) return {6'b000000, m_ovf, m_en};
        return 8'h00;
    endfunction

    task automatic model_edge(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d);
        logic commit;
        logic load;
        commit = 1'b0;
        if (!m_ready) begin
            m_clr_edges++;
            if (m_clr_edges == 240) begin
                for (int i = 0; i < 240; i++) m_ram[i] = 8'h00;
                m_ready = 1'b1;
            end
        end else begin
            commit = (cmd == 8'h01) && ((m_prev_cmd != 8'h01) || (m_prev_addr != a));
        end
        load = commit && (a == 8'hF2);
        if (m_en && !load && m_cnt == 8'hFF) m_ovf = 1'b1;
        else if (commit && a == 8'hF3 && d[1]) m_ovf = 1'b0;
        if (load) m_cnt = d;
        else if (m_en) m_cnt = m_cnt + 8'd1;
        if (commit && a == 8'hF3) m_en = d[0];
        if (commit && a < 8'hF0) m_ram[a] = d;
        if (commit && a == 8'hF0) m_gpio_out = d;
        m_s2 = m_s1;
        m_s1 = gpio_in;
        m_prev_cmd = cmd;
        m_prev_addr = a;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: inputs set just after an edge, model advanced on the next edge
    task automatic step(input logic [7:0] cmd, input logic [7:0] a, input logic drv, input logic [7:0] wd);
        bus_if.cmd_memory  = cmd;
        bus_if.addr_memory = a;
        tb_drv   = drv;
        tb_wdata = wd;
        if (!rst && cmd == CMD_READ) begin
            exp_q.push_back(model_read(a));
            tag_q.push_back(a);
        end
        @(posedge clk);
        if (!rst) model_edge(cmd, a, drv ? wd : 8'h00);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step(CMD_WRITE, a, 1'b1, d);
    endtask

    task automatic rd(input logic [7:0] a);
        step(CMD_READ, a, 1'b0, 8'h00);
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        model_reset();
        tb_drv = 1'b0;
    endtask

    // Monitor: status outputs every cycle, read data whenever the DUT drives the bus
    always @(negedge clk) begin
        logic [7:0] e, t;
        check8("mem_ready", {7'b0, mem_ready}, {7'b0, m_ready});
        check8("gpio_out", gpio_out, m_gpio_out);
        check8("timer_ovf", {7'b0, timer_ovf}, {7'b0, m_ovf});
        if (!rst && bus_if.cmd_memory == CMD_READ && !tb_drv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got read %h with no expectation", data_memory);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (data_memory !== e) begin
                    errors++;
                    $display("FAIL read@%h: got %h expected %h at %0t", t, data_memory, e, $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lc, la, c, a, d;
        logic       ld;
        bus_if.cmd_memory  = CMD_READ;
        bus_if.addr_memory = 8'h37;
        model_reset();
        for (int i = 0; i < 240; i++) m_ram[i] = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clear sweep: reads are zero and ready rises on edge 240
        for (int i = 1; i <= 240; i++) begin
            rd(8'h37);
            if (i == 239) check8("ready_edge239", {7'b0, mem_ready}, 8'h00);
            if (i == 240) check8("ready_edge240", {7'b0, mem_ready}, 8'h01);
        end

        // Single commit with CU holding WRITE after releasing the bus
        wr(8'h10, 8'h5A);
        for (int i = 0; i < 3; i++) step(CMD_WRITE, 8'h10, 1'b0, 8'h00);
        rd(8'h10);

        // Back-to-back writes differing only in address
        wr(8'h20, 8'h11);
        wr(8'h21, 8'h22);
        rd(8'h20);
        rd(8'h21);

        // GPIO out and synchronised GPIO in
        wr(8'hF0, 8'hA5);
        check8("gpio_out_direct", gpio_out, 8'hA5);
        gpio_in = 8'h3C;
        for (int i = 0; i < 4; i++) rd(8'hF1);

        // Timer wrap sets overflow, W1C clears it with enable kept
        wr(8'hF2, 8'hFE);
        wr(8'hF3, 8'h01);
        rd(8'hF2);
        rd(8'hF2);
        rd(8'hF3);
        check8("tmr_ovf_direct", {7'b0, timer_ovf}, 8'h01);
        wr(8'hF3, 8'h03);
        rd(8'hF3);
        wr(8'hF3, 8'h00);
        rd(8'hF3);
        rd(8'hF4);

        // Reset in RUN, then mid-sweep, then a full sweep clears RAM
        wr(8'h10, 8'h77);
        wr(8'hE0, 8'h99);
        assert_rst();
        #1;
        check8("rst_gpio_out", gpio_out, 8'h00);
        check8("rst_mem_ready", {7'b0, mem_ready}, 8'h00);
        step(CMD_READ, 8'h10, 1'b0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) rd(8'h10);
        assert_rst();
        step(CMD_WRITE, 8'h10, 1'b0, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 240; i++) rd(8'h55);
        rd(8'h10);
        rd(8'hE0);
        check8("ram10_after_clear", data_memory, 8'h00);

        // Randomised traffic
        lc = CMD_READ; la = 8'h00;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) gpio_in = 8'($urandom);
            a = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
            d = 8'($urandom);
            ld = 1'b0;
            case ($urandom_range(0, 7))
                0, 1, 2: c = CMD_READ;
                3, 4, 5: begin c = CMD_WRITE; ld = 1'b1; end
                6:       c = 8'($urandom_range(2, 255));
                default: begin c = lc; a = la; end
            endcase
            step(c, a, ld, d);
            lc = c;
            la = a;
        end

        rd(8'hF3);
        step(8'h55, 8'h00, 1'b0, 8'h00);
        step(8'h55, 8'h00, 1'b0, 8'h00);
        check8("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
